mips_pipe_skid_stage: RTL
=========================

// Module: mips_pipe_skid_stage
// PURPOSE
//   Elastic pipeline stage register for the MIPS pipeline: the consumer-side counterpart of the plain
//   stage flip-flops. It accepts a beat from the upstream stage with a valid/ready handshake, holds
//   it, and presents it to the downstream stage. A 2-entry skid keeps full throughput under
//   back-pressure, and flush squashes in-flight beats on branch/jump redirect.
// PARAMETERS
//   WIDTH     32   payload width in bits (instr, PC, control bundle, ...)
//   RST_DATA  0    value loaded into both payload registers on reset and on flush
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-low reset (sampled on rising clk edge only)
//   flush      in   1      squash all held beats; highest priority after reset
//   in_valid   in   1      upstream beat valid
//   in_ready   out  1      stage can accept a beat this cycle (registered)
//   in_data    in   WIDTH  upstream payload
//   out_valid  out  1      downstream beat valid (registered)
//   out_ready  in   1      downstream accepts this cycle
//   out_data   out  WIDTH  downstream payload (registered, from main register)
//   count      out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//   - Accept: in_valid & in_ready at a rising edge. Issue: out_valid & out_ready at a rising edge.
//   - Storage: main reg (drives out_*) and skid reg. All outputs come straight from flops.
//   - States: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
//     EMPTY: accept -> ONE, main<=in_data. Otherwise stay.
//     ONE:   accept & issue -> ONE, main<=in_data. Accept only -> FULL, skid<=in_data.
//            Issue only -> EMPTY. Neither -> stay.
//     FULL:  issue -> ONE, main<=skid. No accept is possible (in_ready=0).
//   - Flags: out_valid = (state!=EMPTY). in_ready = (state!=FULL). count follows the state.
//   - Latency: 1 cycle from accept into EMPTY to out_valid. Throughput: 1 beat/cycle when out_ready=1.
//   - Ordering: strict FIFO. The skid beat is always issued after the main beat. No beat is duplicated
//     or dropped except by flush.
//   - Payload is stable while out_valid=1 and out_ready=0. in_ready never depends combinationally
//     on out_ready.
//   - Flush: next state EMPTY. main/skid <= RST_DATA, out_valid=0, in_ready=1, count=0.
//     A beat accepted in the flush cycle is discarded. A beat issued in the flush cycle counts as
//     delivered.
//   - Reset (rst=0 at edge): state EMPTY, out_valid=0, in_ready=1, count=0, out_data=RST_DATA,
//     skid=RST_DATA. Reset overrides flush and handshakes. Asserting reset mid-transfer drops all
//     held beats. Reset has no asynchronous effect.
//   - Illegal or unused state encodings recover to EMPTY on the next edge.
// TESTING
//   1. Reset: hold rst=0 for 2 clks with in_valid=1 -> out_valid=0, in_ready=1, count=0,
//      out_data=0; after release, first beat appears 1 clk later.
//   2. Streaming: out_ready=1, beats 0x11,0x22,0x33 on consecutive clks -> out_data 0x11,0x22,0x33
//      on consecutive clks, in_ready stays 1, count stays 1.
//   3. Back-pressure: out_ready=0, push 0xA then 0xB -> count=2, in_ready=0, out_data=0xA held;
//      raise out_ready -> 0xA then 0xB delivered, in_ready=1 one clk after the first issue.
//   4. Flush in FULL: state holds 0xA/0xB and flush=1 with in_valid=1, in_data=0xC -> next clk
//      out_valid=0, count=0; 0xA, 0xB and 0xC never appear.
//   5. Simultaneous events in ONE: accept 0x5 and issue 0x4 on the same edge -> count stays 1,
//      out_data=0x5.
//   6. Random valid/ready (10k cycles) vs. scoreboard -> in-order, no loss or duplication, and
//      out_data stable while stalled.

Source files
------------

// File: rtl/mips_pipe_skid_stage.sv
// Elastic MIPS pipeline stage: main + skid register pair with
// valid/ready handshakes, flush squash and registered flags.
module mips_pipe_skid_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [1:0]       count_q, count_d;
  logic             accept, issue;

  assign accept = in_valid & in_ready_q;
  assign issue  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && issue) begin
          main_d = in_data;
        end else if (accept) begin
          state_d = ST_FULL;
          skid_d  = in_data;
        end else if (issue) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (issue) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash everything held; a beat issued this cycle is already delivered.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RST_DATA;
      skid_d  = RST_DATA;
    end
  end

  always_comb begin
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
    count_d     = 2'd0;
    if (state_d == ST_ONE)  count_d = 2'd1;
    if (state_d == ST_FULL) count_d = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= RST_DATA;
      skid_q      <= RST_DATA;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign count     = count_q;

endmodule
